// File: rtl/aud_pkg.sv
// rtl/aud_pkg.sv - shared types and constants for the I2S audio player
package aud_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_PAD
    } player_state_e;

    localparam int AUD_DATA_W = 16;

endpackage

// File: rtl/aud_lrck_edge.sv
// rtl/aud_lrck_edge.sv - LRCK edge detector; the first edge after reset only arms it
module aud_lrck_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_daclrck,
    output logic o_rise,
    output logic o_fall
);

    logic lrck_d_r;
    logic armed_r;
    logic lrck_edge;

    assign lrck_edge = i_daclrck ^ lrck_d_r;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lrck_d_r <= 1'b0;
            armed_r  <= 1'b0;
        end else begin
            lrck_d_r <= i_daclrck;
            if (lrck_edge) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Unarmed edges are swallowed so LRCK high at reset release is not a frame boundary
    assign o_rise = lrck_edge & armed_r & i_daclrck;
    assign o_fall = lrck_edge & armed_r & ~i_daclrck;

endmodule

// File: rtl/aud_i2s_player.sv
// rtl/aud_i2s_player.sv - mono PCM to WM8731 I2S DACDAT serialiser; AUD_PLAYER_VOLUME_EN adds i_vol_shift
module aud_i2s_player
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W,
    parameter int CNT_W  = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_daclrck,
    input  logic [DATA_W-1:0] i_dac_data,
    input  logic              i_valid,
`ifdef AUD_PLAYER_VOLUME_EN
    input  logic [2:0]        i_vol_shift,
`endif
    output logic              o_aud_dacdat,
    output logic              o_busy,
    output logic              o_underrun,
    output logic              o_frame_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    player_state_e     state_r, state_n;
    logic [DATA_W-1:0] shift_r, shift_n;
    logic [DATA_W-1:0] frame_r, frame_n;
    logic [CNT_W-1:0]  bit_cnt_r, cnt_n;
    logic              dacdat_n, underrun_n, frame_err_n;

    logic              lrck_rise, lrck_fall;
    logic [DATA_W-1:0] sample_in, sample_left, load_word;
    logic              load_left, load_right;

    aud_lrck_edge u_lrck_edge (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_daclrck (i_daclrck),
        .o_rise    (lrck_rise),
        .o_fall    (lrck_fall)
    );

    assign sample_in = i_valid ? i_dac_data : '0;

`ifdef AUD_PLAYER_VOLUME_EN
    // Attenuated value goes into frame_r, so the right channel reuses the left's shift
    assign sample_left = DATA_W'($signed(sample_in) >>> i_vol_shift);
`else
    assign sample_left = sample_in;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r      <= S_IDLE;
            shift_r      <= '0;
            frame_r      <= '0;
            bit_cnt_r    <= '0;
            o_aud_dacdat <= 1'b0;
            o_underrun   <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state_r      <= state_n;
            shift_r      <= shift_n;
            frame_r      <= frame_n;
            bit_cnt_r    <= cnt_n;
            o_aud_dacdat <= dacdat_n;
            o_underrun   <= underrun_n;
            o_frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state_r;
        shift_n     = shift_r;
        frame_n     = frame_r;
        cnt_n       = bit_cnt_r;
        dacdat_n    = 1'b0;
        underrun_n  = 1'b0;
        frame_err_n = 1'b0;
        load_left   = 1'b0;
        load_right  = 1'b0;
        load_word   = '0;

        case (state_r)
            S_IDLE: begin
                if (lrck_fall && i_en) begin
                    load_left = 1'b1;
                end
            end
            S_SHIFT: begin
                if (lrck_rise || lrck_fall) begin
                    // An edge landing right after the last bit is a full word, not an error
                    frame_err_n = (bit_cnt_r != LAST_CNT);
                    if (lrck_rise) begin
                        load_right = 1'b1;
                    end else if (i_en) begin
                        load_left = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else if (bit_cnt_r == LAST_CNT) begin
                    state_n = S_PAD;
                end else begin
                    dacdat_n = shift_r[DATA_W-1];
                    shift_n  = shift_r << 1;
                    cnt_n    = bit_cnt_r + 1'b1;
                end
            end
            S_PAD: begin
                if (lrck_rise) begin
                    load_right = 1'b1;
                end else if (lrck_fall) begin
                    if (i_en) begin
                        load_left = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (load_left) begin
            underrun_n = ~i_valid;
            frame_n    = sample_left;
            load_word  = sample_left;
        end else if (load_right) begin
            load_word  = frame_r;
        end

        // MSB leaves on the edge cycle itself, giving the I2S one-BCLK delay
        if (load_left || load_right) begin
            state_n  = S_SHIFT;
            dacdat_n = load_word[DATA_W-1];
            shift_n  = load_word << 1;
            cnt_n    = CNT_W'(1);
        end
    end

    assign o_busy = (state_r == S_SHIFT);

endmodule

// File: tb/tb_aud_i2s_player.sv
// tb/tb_aud_i2s_player.sv - directed self-checking bench for aud_i2s_player
module tb_aud_i2s_player;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic        i_daclrck = 1'b0;
    logic [15:0] i_dac_data = 16'h0000;
    logic        i_valid = 1'b0;
`ifdef AUD_PLAYER_VOLUME_EN
    logic [2:0]  i_vol_shift = 3'd0;
`endif
    logic        o_aud_dacdat;
    logic        o_busy;
    logic        o_underrun;
    logic        o_frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    aud_i2s_player dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_daclrck    (i_daclrck),
        .i_dac_data   (i_dac_data),
        .i_valid      (i_valid),
`ifdef AUD_PLAYER_VOLUME_EN
        .i_vol_shift  (i_vol_shift),
`endif
        .o_aud_dacdat (o_aud_dacdat),
        .o_busy       (o_busy),
        .o_underrun   (o_underrun),
        .o_frame_err  (o_frame_err)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One LRCK half of n BCLKs; expected DACDAT is word MSB first from the first cycle after the edge
    task automatic half(input logic lv, input int n, input logic [15:0] word, input logic active,
                        input logic exp_err, input logic exp_und, input string name);
        logic [15:0] w;
        logic        exp_bit, exp_busy, exp_e, exp_u;
        w = active ? word : 16'h0000;
        i_daclrck = lv;
        for (int j = 1; j <= n; j++) begin
            tick();
            exp_bit  = w[15];
            w        = w << 1;
            exp_busy = active && (j <= 16);
            exp_e    = (j == 1) ? exp_err : 1'b0;
            exp_u    = (j == 1) ? exp_und : 1'b0;
            n_checks++;
            if (o_aud_dacdat !== exp_bit) begin
                n_fail++;
                $display("FAIL %s dacdat cycle %0d: got %b expected %b", name, j, o_aud_dacdat, exp_bit);
            end
            n_checks++;
            if (o_busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, j, o_busy, exp_busy);
            end
            n_checks++;
            if (o_frame_err !== exp_e) begin
                n_fail++;
                $display("FAIL %s frame_err cycle %0d: got %b expected %b", name, j, o_frame_err, exp_e);
            end
            n_checks++;
            if (o_underrun !== exp_u) begin
                n_fail++;
                $display("FAIL %s underrun cycle %0d: got %b expected %b", name, j, o_underrun, exp_u);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        n_checks++;
        if ({o_aud_dacdat, o_busy, o_underrun, o_frame_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s: got dacdat/busy/underrun/frame_err=%b%b%b%b expected 0000",
                     name, o_aud_dacdat, o_busy, o_underrun, o_frame_err);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset_hold");
        i_rst = 1'b0;
        tick();
        check_idle_outputs("reset_release");
    endtask

    task automatic test_basic();
        i_en       = 1'b1;
        i_valid    = 1'b1;
        i_dac_data = 16'hA5C3;
        half(1'b1, 32, 16'h0000, 1'b0, 1'b0, 1'b0, "arm_edge");
        half(1'b0, 32, 16'hA5C3, 1'b1, 1'b0, 1'b0, "t1_left");
        half(1'b1, 32, 16'hA5C3, 1'b1, 1'b0, 1'b0, "t1_right");
    endtask

    task automatic test_data_change();
        half(1'b0, 32, 16'hA5C3, 1'b1, 1'b0, 1'b0, "t2_left");
        i_dac_data = 16'h1234;
        half(1'b1, 32, 16'hA5C3, 1'b1, 1'b0, 1'b0, "t2_right_held");
        half(1'b0, 32, 16'h1234, 1'b1, 1'b0, 1'b0, "t2_left_new");
        half(1'b1, 32, 16'h1234, 1'b1, 1'b0, 1'b0, "t2_right_new");
    endtask

    task automatic test_underrun();
        i_valid = 1'b0;
        half(1'b0, 32, 16'h0000, 1'b1, 1'b0, 1'b1, "t3_left");
        i_valid = 1'b1;
        half(1'b1, 32, 16'h0000, 1'b1, 1'b0, 1'b0, "t3_right");
        half(1'b0, 32, 16'h1234, 1'b1, 1'b0, 1'b0, "t3_recover_left");
        half(1'b1, 32, 16'h1234, 1'b1, 1'b0, 1'b0, "t3_recover_right");
    endtask

    task automatic test_enable_off();
        i_dac_data = 16'hA5C3;
        half(1'b0, 32, 16'hA5C3, 1'b1, 1'b0, 1'b0, "en_left");
        i_en = 1'b0;
        half(1'b1, 32, 16'hA5C3, 1'b1, 1'b0, 1'b0, "en_off_right");
        half(1'b0, 32, 16'h0000, 1'b0, 1'b0, 1'b0, "en_off_idle_l");
        half(1'b1, 32, 16'h0000, 1'b0, 1'b0, 1'b0, "en_off_idle_r");
        i_en = 1'b1;
    endtask

    task automatic test_short_frames();
        half(1'b0, 12, 16'hA5C3, 1'b1, 1'b0, 1'b0, "t4_l0");
        half(1'b1, 12, 16'hA5C3, 1'b1, 1'b1, 1'b0, "t4_r0");
        i_dac_data = 16'h1234;
        half(1'b0, 12, 16'h1234, 1'b1, 1'b1, 1'b0, "t4_l1");
        half(1'b1, 12, 16'h1234, 1'b1, 1'b1, 1'b0, "t4_r1");
        half(1'b0, 16, 16'h1234, 1'b1, 1'b1, 1'b0, "t4_l16");
        half(1'b1, 16, 16'h1234, 1'b1, 1'b0, 1'b0, "t4_r16_exact");
        half(1'b0, 32, 16'h1234, 1'b1, 1'b0, 1'b0, "t4_l32_exact");
        half(1'b1, 32, 16'h1234, 1'b1, 1'b0, 1'b0, "t4_r32");
    endtask

    task automatic test_reset_midword();
        i_dac_data = 16'hA5C3;
        i_daclrck  = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
        end
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_midword_busy: got %b expected 1", o_busy);
        end
        i_rst     = 1'b1;
        i_daclrck = 1'b1;
        tick();
        check_idle_outputs("t5_reset_midword");
        tick();
        i_rst = 1'b0;
        half(1'b1, 32, 16'h0000, 1'b0, 1'b0, 1'b0, "t5_lrck_high_release");
        half(1'b0, 32, 16'hA5C3, 1'b1, 1'b0, 1'b0, "t5_first_left");
        half(1'b1, 32, 16'hA5C3, 1'b1, 1'b0, 1'b0, "t5_first_right");
    endtask

`ifdef AUD_PLAYER_VOLUME_EN
    task automatic test_volume();
        i_vol_shift = 3'd3;
        i_dac_data  = 16'h8000;
        half(1'b0, 32, 16'hF000, 1'b1, 1'b0, 1'b0, "t6_left");
        i_vol_shift = 3'd0;
        half(1'b1, 32, 16'hF000, 1'b1, 1'b0, 1'b0, "t6_right");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_data_change();
        test_underrun();
        test_enable_off();
        test_short_frames();
        test_reset_midword();
`ifdef AUD_PLAYER_VOLUME_EN
        test_volume();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
